// File: rtl/pacman_input_ctrl.sv
// Player-input front end for the pacman core. Decodes PS/2 key events,
// merges them with the two joysticks, applies optional rotation and 4-way
// last-pressed-wins direction logic, stretches coin presses into fixed
// pulses and presents registered, active-low in0/in1 bytes.
module pacman_input_ctrl #(
  parameter int unsigned COIN_LEN = 2400000,
  parameter int unsigned CNT_W    = 22
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        cocktail,
  output logic [7:0]  in0,
  output logic [7:0]  in1
);

  // Key register slots. Direction vectors use the order {U, D, L, R},
  // so keys[3:0] is player 1 and keys[7:4] is player 2.
  localparam logic [4:0] K_R      = 5'd0;
  localparam logic [4:0] K_L      = 5'd1;
  localparam logic [4:0] K_D      = 5'd2;
  localparam logic [4:0] K_U      = 5'd3;
  localparam logic [4:0] K_R2     = 5'd4;
  localparam logic [4:0] K_L2     = 5'd5;
  localparam logic [4:0] K_D2     = 5'd6;
  localparam logic [4:0] K_U2     = 5'd7;
  localparam logic [4:0] K_FIRE29 = 5'd8;
  localparam logic [4:0] K_FIRE14 = 5'd9;
  localparam logic [4:0] K_FIRE03 = 5'd10;
  localparam logic [4:0] K_FIRE1C = 5'd11;
  localparam logic [4:0] K_ST1_05 = 5'd12;
  localparam logic [4:0] K_ST1_16 = 5'd13;
  localparam logic [4:0] K_ST2_06 = 5'd14;
  localparam logic [4:0] K_ST2_1E = 5'd15;
  localparam logic [4:0] K_COIN04 = 5'd16;
  localparam logic [4:0] K_COIN36 = 5'd17;
  localparam logic [4:0] K_COINB  = 5'd18;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_HOLD} coin_state_t;

  logic [18:0]      keys;
  logic             toggle_q;
  logic             primed;
  logic             key_hit;
  logic [4:0]       key_idx;

  logic [15:0]      joy;
  logic [3:0]       raw1, raw2, prev1, prev2, mask1, mask2;
  logic [3:0]       new1, new2, mask1_next, mask2_next, dir1, dir2;
  logic             fire, start1, start2;
  logic [1:0]       coin_raw, coin_raw_q, coin_n;
  coin_state_t      coin_state [2];
  logic [CNT_W-1:0] coin_cnt   [2];
  logic [4:0]       out0_q;
  logic [7:0]       out1_q;
  logic             unused_joy;

  // Horizontal cabinet: U<=L, D<=R, L<=D, R<=U on a {U, D, L, R} vector.
  function automatic logic [3:0] rot(input logic [3:0] v, input logic en);
    return en ? {v[1], v[0], v[2], v[3]} : v;
  endfunction

  // One-hot of the highest-priority set bit, U > D > L > R.
  function automatic logic [3:0] first_bit(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else           return 4'b0001;
  endfunction

  // Map a scan code to a key slot; only the arrow keys ignore the extended bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    key_hit = 1'b0;
    key_idx = K_R;
    case (ps2_key[7:0])
      8'h75: begin key_hit = 1'b1;         key_idx = K_U;      end
      8'h72: begin key_hit = 1'b1;         key_idx = K_D;      end
      8'h6B: begin key_hit = 1'b1;         key_idx = K_L;      end
      8'h74: begin key_hit = 1'b1;         key_idx = K_R;      end
      8'h29: begin key_hit = !ps2_key[8];  key_idx = K_FIRE29; end
      8'h14: begin key_hit = !ps2_key[8];  key_idx = K_FIRE14; end
      8'h03: begin key_hit = !ps2_key[8];  key_idx = K_FIRE03; end
      8'h1C: begin key_hit = !ps2_key[8];  key_idx = K_FIRE1C; end
      8'h05: begin key_hit = !ps2_key[8];  key_idx = K_ST1_05; end
      8'h16: begin key_hit = !ps2_key[8];  key_idx = K_ST1_16; end
      8'h06: begin key_hit = !ps2_key[8];  key_idx = K_ST2_06; end
      8'h1E: begin key_hit = !ps2_key[8];  key_idx = K_ST2_1E; end
      8'h04: begin key_hit = !ps2_key[8];  key_idx = K_COIN04; end
      8'h36: begin key_hit = !ps2_key[8];  key_idx = K_COIN36; end
      8'h2E: begin key_hit = !ps2_key[8];  key_idx = K_COINB;  end
      8'h2D: begin key_hit = !ps2_key[8];  key_idx = K_U2;     end
      8'h2B: begin key_hit = !ps2_key[8];  key_idx = K_D2;     end
      8'h23: begin key_hit = !ps2_key[8];  key_idx = K_L2;     end
      8'h34: begin key_hit = !ps2_key[8];  key_idx = K_R2;     end
      default: ;
    endcase
  end

  // Track the event toggle and latch the pressed state of mapped keys.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RESET_N) begin
      toggle_q <= 1'b0;
      primed   <= 1'b0;
      keys     <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      primed   <= 1'b1;
      if (primed && (ps2_key[10] != toggle_q) && key_hit)
        keys[key_idx] <= ps2_key[9];
    end
  end

  // Merge keys with joysticks, rotate, and resolve 4-way directions.
  always_comb begin
    joy        = joystick_0 | joystick_1;
    raw1       = rot(keys[3:0] | joy[3:0], rotate);
    raw2       = rot(keys[7:4] | joy[3:0], rotate);
    new1       = raw1 & ~prev1;
    new2       = raw2 & ~prev2;
    mask1_next = (new1 != 4'b0) ? first_bit(new1) : mask1;
    mask2_next = (new2 != 4'b0) ? first_bit(new2) : mask2;
    dir1       = raw1 & mask1_next;
    dir2       = raw2 & mask2_next;
    fire       = keys[K_FIRE29] | keys[K_FIRE14] | keys[K_FIRE03] | keys[K_FIRE1C] | joy[4];
    start1     = keys[K_ST1_05] | keys[K_ST1_16] | joy[5];
    start2     = keys[K_ST2_06] | keys[K_ST2_1E] | joy[6];
    coin_raw   = {keys[K_COINB], keys[K_COIN04] | keys[K_COIN36] | joy[7]};
  end

  assign unused_joy = &{1'b0, joy[15:8]};

  // Direction history, masks and the registered active-low output bits.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      prev1  <= '0;
      prev2  <= '0;
      mask1  <= '0;
      mask2  <= '0;
      out0_q <= 5'h1F;
      out1_q <= 8'hFF;
    end else begin
      prev1  <= raw1;
      prev2  <= raw2;
      mask1  <= mask1_next;
      mask2  <= mask2_next;
      out0_q <= ~{fire, dir1[2], dir1[0], dir1[1], dir1[3]};
      out1_q <= ~{cocktail, start2, start1, 1'b0, dir2[2], dir2[0], dir2[1], dir2[3]};
    end
  end

  // Coin pulse stretchers: one fixed-length pulse per rising edge, with
  // edges arriving during the pulse or while held afterwards ignored.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      coin_raw_q <= '0;
      coin_n     <= 2'b11;
      for (int c = 0; c < 2; c++) begin
        coin_state[c] <= C_IDLE;
        coin_cnt[c]   <= '0;
      end
    end else begin
      coin_raw_q <= coin_raw;
      for (int c = 0; c < 2; c++) begin
        case (coin_state[c])
          C_IDLE: begin
            if (coin_raw[c] && !coin_raw_q[c]) begin
              coin_state[c] <= C_PULSE;
              coin_cnt[c]   <= CNT_W'(COIN_LEN - 1);
              coin_n[c]     <= 1'b0;
            end
          end
          C_PULSE: begin
            if (coin_cnt[c] == '0) begin
              coin_state[c] <= coin_raw[c] ? C_HOLD : C_IDLE;
              coin_n[c]     <= 1'b1;
            end else begin
              coin_cnt[c] <= coin_cnt[c] - 1'b1;
            end
          end
          C_HOLD: begin
            if (!coin_raw[c]) coin_state[c] <= C_IDLE;
          end
          default: begin
            coin_state[c] <= C_IDLE;
            coin_n[c]     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in0 = {1'b1, coin_n, out0_q};
  assign in1 = out1_q;

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Directed self-checking bench for pacman_input_ctrl with a short coin pulse.
module tb_pacman_input_ctrl;

  logic        clk_sys;
  logic        RESET_N;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        cocktail;
  logic [7:0]  in0;
  logic [7:0]  in1;

  int   errors = 0;
  int   checks = 0;
  logic tog;
  int   low_cnt;

  pacman_input_ctrl #(.COIN_LEN(8), .CNT_W(4)) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (RESET_N),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .cocktail   (cocktail),
    .in0        (in0),
    .in1        (in1)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Produce one PS/2 event by flipping the toggle bit.
  task automatic key(input logic pressed, input logic [8:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    // T1: reset with the toggle bit high and a mapped pressed code present
    RESET_N    = 1'b0;
    tog        = 1'b1;
    ps2_key    = {1'b1, 1'b1, 9'h175};
    joystick_0 = '0;
    joystick_1 = '0;
    rotate     = 1'b0;
    cocktail   = 1'b0;
    tick();
    tick();
    check("rst_in0", in0, 8'hFF);
    check("rst_in1", in1, 8'hFF);
    RESET_N = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_in0", in0, 8'hFF);
    check("post_rst_in1", in1, 8'hFF);

    // T2: 4-way last-pressed-wins
    joystick_0 = 16'h0008;
    tick();
    check("u_press", in0, 8'hFE);
    for (int i = 0; i < 4; i++) tick();
    check("u_held", in0, 8'hFE);
    joystick_0 = 16'h0009;
    tick();
    check("r_wins", in0, 8'hFB);
    for (int i = 0; i < 3; i++) tick();
    check("r_held", in0, 8'hFB);
    joystick_0 = 16'h0008;
    tick();
    check("r_release", in0, 8'hFF);
    tick();
    check("u_still_masked", in0, 8'hFF);
    joystick_0 = 16'h0000;
    tick();
    joystick_1 = 16'h0004;
    tick();
    check("joy1_down", in0, 8'hF7);
    joystick_1 = 16'h0000;
    tick();
    check("joy1_release", in0, 8'hFF);

    // T3: key map and one-clock key latency
    key(1'b1, 9'h175);
    tick();
    check("key_latency", in0, 8'hFF);
    tick();
    check("key_up_ext", in0, 8'hFE);
    key(1'b0, 9'h075);
    tick();
    tick();
    check("key_up_rel", in0, 8'hFF);
    key(1'b1, 9'h01C);
    tick();
    tick();
    check("key_fire_1c", in0, 8'hEF);
    key(1'b1, 9'h099);
    tick();
    tick();
    check("key_unmapped", in0, 8'hEF);
    key(1'b0, 9'h01C);
    tick();
    tick();
    check("key_fire_rel", in0, 8'hFF);
    key(1'b1, 9'h02D);
    tick();
    tick();
    check("key_u2", in1, 8'hFE);
    key(1'b0, 9'h02D);
    tick();
    key(1'b1, 9'h016);
    tick();
    tick();
    check("key_start1", in1, 8'hDF);
    key(1'b0, 9'h016);
    tick();
    tick();
    check("key_start1_rel", in1, 8'hFF);

    // T4: coin pulse stretching
    joystick_0 = 16'h0080;
    low_cnt    = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) check("coin_first", in0, 8'hDF);
      if (!in0[5]) low_cnt++;
    end
    check("coin_held_len", 8'(low_cnt), 8'd8);
    joystick_0 = 16'h0000;
    tick();
    tick();
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 3) joystick_0 = 16'h0080;
      else                  joystick_0 = 16'h0000;
      tick();
      if (!in0[5]) low_cnt++;
    end
    check("coin_repress_len", 8'(low_cnt), 8'd8);
    key(1'b1, 9'h02E);
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!in0[6]) low_cnt++;
    end
    check("coinb_len", 8'(low_cnt), 8'd8);
    key(1'b0, 9'h02E);
    tick();
    tick();
    check("coinb_idle", in0, 8'hFF);

    // T5: rotation, cocktail and simultaneous presses
    rotate     = 1'b1;
    joystick_0 = 16'h0002;
    tick();
    check("rot_l_to_u", in0, 8'hFE);
    joystick_0 = 16'h0000;
    tick();
    joystick_0 = 16'h0004;
    tick();
    check("rot_d_to_l", in0, 8'hFD);
    joystick_0 = 16'h0000;
    cocktail   = 1'b1;
    tick();
    check("cocktail", in1, 8'h7F);
    joystick_0 = 16'h000A;
    tick();
    check("rot_simul_u", in0, 8'hFE);
    rotate     = 1'b0;
    joystick_0 = 16'h0000;
    tick();
    joystick_0 = 16'h0009;
    tick();
    check("simul_u_r", in0, 8'hFE);

    // Reset mid-operation takes effect without a clock edge
    RESET_N = 1'b0;
    #1;
    check("async_rst_in0", in0, 8'hFF);
    check("async_rst_in1", in1, 8'hFF);
    joystick_0 = 16'h0000;
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    check("final_idle", in0, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
